// File: rtl/order_pkg.sv
// -----------------------------------------------------------------------------
// order_pkg
// Shared definitions for the match_scheduler slice.
//   state_t          : scheduler FSM states
//   SIDE_BUY/SELL    : encoding of the per-requester side bit
//   EMPTY_BID/ASK    : empty-book sentinels for the default price width
//   PRICE_W_DEFAULT  : default price width
// -----------------------------------------------------------------------------
package order_pkg;

    localparam int PRICE_W_DEFAULT = 8;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    // Sentinels are all-zeros (bid) and all-ones (ask); users replicate bit 0
    // to build the sentinel at any price width.
    localparam logic [PRICE_W_DEFAULT-1:0] EMPTY_BID = '0;
    localparam logic [PRICE_W_DEFAULT-1:0] EMPTY_ASK = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        MATCH,
        CLEAR
    } state_t;

endpackage

// File: rtl/match_scheduler_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with a registered last-grant pointer.
//   clk, reset   : clock, asynchronous active-high reset
//   req[1:0]     : request vector
//   advance      : commit the current grant to the pointer
//   grant_valid  : at least one request present
//   grant_idx    : index of the winning requester
// After reset the pointer favours requester 0.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic last_q;   // index granted most recently

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b11:   grant_idx = ~last_q;
            2'b10:   grant_idx = 1'b1;
            default: grant_idx = 1'b0;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_q <= 1'b1;
        else if (advance && grant_valid)
            last_q <= grant_idx;
    end

endmodule

// File: rtl/match_scheduler.sv
// -----------------------------------------------------------------------------
// match_scheduler
// Front-end controller for the order-matching datapath: arbitrates two order
// requesters, keeps a one-deep best-bid/best-ask book, detects crossed books
// and sequences each match for the downstream spread block.
//
// Ports
//   clk, reset              : clock, asynchronous active-high reset
//   req[1:0], side[1:0]     : per-requester request (held until ack) and side
//   price0, price1          : per-requester order price
//   ack[1:0], reject        : one-hot acceptance pulse; reject = sentinel order
//   session_start/stop      : open/close the trading window (stop wins)
//   enable_count            : session-active flag
//   match_signal            : one-cycle match strobe
//   buy_price, sell_price   : current best bid / best ask
//   trade_count             : matches executed while the session was active
//   busy                    : FSM not in IDLE
//   trade_price             : midpoint of the last match (optional)
//
// Build option: define MATCH_SCHEDULER_TRADE_PRICE_EN to add trade_price.
// -----------------------------------------------------------------------------
module match_scheduler
    import order_pkg::*;
#(
    parameter int PRICE_W = PRICE_W_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [1:0]         side,
    input  logic [PRICE_W-1:0] price0,
    input  logic [PRICE_W-1:0] price1,
    output logic [1:0]         ack,
    output logic               reject,
    input  logic               session_start,
    input  logic               session_stop,
    output logic               enable_count,
    output logic               match_signal,
    output logic [PRICE_W-1:0] buy_price,
    output logic [PRICE_W-1:0] sell_price,
    output logic [CNT_W-1:0]   trade_count,
    output logic               busy
`ifdef MATCH_SCHEDULER_TRADE_PRICE_EN
    ,
    output logic [PRICE_W-1:0] trade_price
`endif
);

    localparam logic [PRICE_W-1:0] BID_NONE = {PRICE_W{EMPTY_BID[0]}};
    localparam logic [PRICE_W-1:0] ASK_NONE = {PRICE_W{EMPTY_ASK[0]}};

    state_t state_q, state_d;

    logic               grant_valid;
    logic               grant_idx;
    logic               win_idx;
    logic               win_side;
    logic [PRICE_W-1:0] win_price;
    logic               order_is_sentinel;
    logic               book_crossed;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .advance     (state_q == IDLE),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign order_is_sentinel = (win_side == SIDE_BUY  && win_price == BID_NONE) ||
                               (win_side == SIDE_SELL && win_price == ASK_NONE);

    // Equal prices are a cross; an empty side never crosses.
    assign book_crossed = (buy_price != BID_NONE) && (sell_price != ASK_NONE) &&
                          (buy_price >= sell_price);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = LOAD;
            LOAD:    state_d = CHECK;
            CHECK:   state_d = book_crossed ? MATCH : IDLE;
            MATCH:   state_d = CLEAR;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ack          = 2'b00;
        reject       = 1'b0;
        match_signal = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            LOAD: begin
                ack    = win_idx ? 2'b10 : 2'b01;
                reject = order_is_sentinel;
            end
            MATCH:   match_signal = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Order latch, book and trade counter ----------------
    // NOTE: the latched order fields are reset along with the book; they are
    // only a few flops and keep post-reset state fully deterministic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_idx     <= 1'b0;
            win_side    <= SIDE_BUY;
            win_price   <= '0;
            buy_price   <= BID_NONE;
            sell_price  <= ASK_NONE;
            trade_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        win_idx   <= grant_idx;
                        win_side  <= side[grant_idx];
                        win_price <= grant_idx ? price1 : price0;
                    end
                end
                LOAD: begin
                    // Sentinel and non-improving orders leave the book as is.
                    if (!order_is_sentinel) begin
                        if (win_side == SIDE_BUY && win_price > buy_price)
                            buy_price <= win_price;
                        if (win_side == SIDE_SELL && win_price < sell_price)
                            sell_price <= win_price;
                    end
                end
                MATCH: begin
                    if (enable_count)
                        trade_count <= trade_count + CNT_W'(1);
                end
                CLEAR: begin
                    buy_price  <= BID_NONE;
                    sell_price <= ASK_NONE;
                end
                default: ;
            endcase
        end
    end

    // ---------------- Session window ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            enable_count <= 1'b0;
        else if (session_stop)
            enable_count <= 1'b0;
        else if (session_start)
            enable_count <= 1'b1;
    end

`ifdef MATCH_SCHEDULER_TRADE_PRICE_EN
    // Midpoint of the crossing prices; the extra sum bit keeps the carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            trade_price <= '0;
        else if (state_q == MATCH)
            trade_price <= PRICE_W'(({1'b0, buy_price} + {1'b0, sell_price}) >> 1);
    end
`endif

endmodule

// File: tb/tb_match_scheduler.sv
// -----------------------------------------------------------------------------
// tb_match_scheduler
// Self-checking bench for match_scheduler. Issuing an order pushes its expected
// ack (and any resulting match) into queues; a negedge monitor pops and
// compares whenever the DUT shows ack or match_signal.
// -----------------------------------------------------------------------------
module tb_match_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] side;
    logic [7:0] price0, price1;
    logic [1:0] ack;
    logic       reject;
    logic       session_start, session_stop;
    logic       enable_count, match_signal;
    logic [7:0] buy_price, sell_price;
    logic [7:0] trade_count;
    logic       busy;
`ifdef MATCH_SCHEDULER_TRADE_PRICE_EN
    logic [7:0] trade_price;
`endif

    always #5 clk = ~clk;

    match_scheduler #(.PRICE_W(8), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .side          (side),
        .price0        (price0),
        .price1        (price1),
        .ack           (ack),
        .reject        (reject),
        .session_start (session_start),
        .session_stop  (session_stop),
        .enable_count  (enable_count),
        .match_signal  (match_signal),
        .buy_price     (buy_price),
        .sell_price    (sell_price),
        .trade_count   (trade_count),
        .busy          (busy)
`ifdef MATCH_SCHEDULER_TRADE_PRICE_EN
        ,
        .trade_price   (trade_price)
`endif
    );

    typedef struct { logic [1:0] ack; logic rej; } ack_exp_t;
    typedef struct { logic [7:0] buy; logic [7:0] sell; logic en; } match_exp_t;

    ack_exp_t   ack_q[$];
    match_exp_t match_q[$];
    ack_exp_t   ea;
    match_exp_t em;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_ack_cyc = 0;

    // Reference book / session model
    logic [7:0] m_buy   = 8'h00;
    logic [7:0] m_sell  = 8'hFF;
    logic       m_en    = 1'b0;
    logic [7:0] m_count = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Expected outcome of one order against the model book.
    function automatic void model_order(input int idx, input logic sd, input logic [7:0] pr);
        ack_exp_t a;
        logic rej;
        rej = (sd == 1'b0 && pr == 8'h00) || (sd == 1'b1 && pr == 8'hFF);
        a.ack = (idx == 0) ? 2'b01 : 2'b10;
        a.rej = rej;
        ack_q.push_back(a);
        if (!rej) begin
            if (sd == 1'b0 && pr > m_buy)  m_buy  = pr;
            if (sd == 1'b1 && pr < m_sell) m_sell = pr;
        end
        if (m_buy != 8'h00 && m_sell != 8'hFF && m_buy >= m_sell) begin
            match_q.push_back('{buy: m_buy, sell: m_sell, en: m_en});
            if (m_en) m_count = m_count + 8'h01;
            m_buy  = 8'h00;
            m_sell = 8'hFF;
        end
    endfunction

    // Monitor: compares DUT output events against the queued expectations.
    always @(negedge clk) begin
        if (!reset) begin
            if (ack == 2'b00 && reject)
                check("reject_without_ack", reject, 1'b0);
            if (ack != 2'b00) begin
                last_ack_cyc = cyc;
                if (ack_q.size() == 0)
                    check("unexpected_ack", ack, 2'b00);
                else begin
                    ea = ack_q.pop_front();
                    check("ack", ack, ea.ack);
                    check("reject", reject, ea.rej);
                end
            end
            if (match_signal) begin
                check("match_latency", cyc - last_ack_cyc, 2);
                if (match_q.size() == 0)
                    check("unexpected_match", match_signal, 1'b0);
                else begin
                    em = match_q.pop_front();
                    check("match_buy", buy_price, em.buy);
                    check("match_sell", sell_price, em.sell);
                    check("match_enable", enable_count, em.en);
                end
            end
        end
    end

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin done = 1; break; end
            @(negedge clk);
        end
        if (!done) check("idle_timeout", busy, 1'b0);
    endtask

    // Issue one order from requester idx; returns at an idle negedge.
    task automatic send(input int idx, input logic sd, input logic [7:0] pr);
        bit got = 0;
        model_order(idx, sd, pr);
        req[idx]  = 1'b1;
        side[idx] = sd;
        if (idx == 0) price0 = pr; else price1 = pr;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack[idx]) begin got = 1; break; end
        end
        if (!got) check("ack_timeout", got, 1'b1);
        req[idx] = 1'b0;
        wait_idle();
    endtask

    task automatic session(input logic start, input logic stop);
        @(negedge clk);
        session_start = start;
        session_stop  = stop;
        @(negedge clk);
        session_start = 1'b0;
        session_stop  = 1'b0;
        if (stop) m_en = 1'b0; else if (start) m_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int n;
        reset = 1'b1; req = 2'b00; side = 2'b00; price0 = 8'h00; price1 = 8'h00;
        session_start = 1'b0; session_stop = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ack", ack, 2'b00);
        check("rst_reject", reject, 1'b0);
        check("rst_match", match_signal, 1'b0);
        check("rst_enable", enable_count, 1'b0);
        check("rst_count", trade_count, 8'h00);
        check("rst_buy", buy_price, 8'h00);
        check("rst_sell", sell_price, 8'hFF);
        check("rst_busy", busy, 1'b0);
`ifdef MATCH_SCHEDULER_TRADE_PRICE_EN
        check("rst_trade_price", trade_price, 8'h00);
`endif

        // Basic buy then crossing sell
        session(1'b1, 1'b0);
        check("session_on", enable_count, 1'b1);
        send(0, 1'b0, 8'h40);
        check("t1_buy", buy_price, 8'h40);
        check("t1_sell", sell_price, 8'hFF);
        check("t1_count0", trade_count, 8'h00);
        send(1, 1'b1, 8'h3C);
        check("t1_count1", trade_count, 8'h01);
        check("t1_clear_buy", buy_price, 8'h00);
        check("t1_clear_sell", sell_price, 8'hFF);

        // Both requesting: grants alternate 0,1,0,1 (last grant was 1)
        model_order(0, 1'b0, 8'h10);
        model_order(1, 1'b0, 8'h12);
        model_order(0, 1'b0, 8'h10);
        model_order(1, 1'b0, 8'h12);
        side = 2'b00; price0 = 8'h10; price1 = 8'h12;
        req  = 2'b11;
        acks = 0;
        for (int i = 0; i < 40 && acks < 4; i++) begin
            @(negedge clk);
            if (ack != 2'b00) acks++;
        end
        req = 2'b00;
        check("rr_ack_count", acks, 4);
        wait_idle();
        check("rr_buy", buy_price, 8'h12);

        // Non-improving buy and sentinel sell
        send(0, 1'b0, 8'h50);
        send(0, 1'b0, 8'h30);
        check("t3_buy_kept", buy_price, 8'h50);
        send(1, 1'b1, 8'hFF);
        check("t3_sell_kept", sell_price, 8'hFF);
        send(1, 1'b1, 8'h50);
        check("t3_count", trade_count, 8'h02);

        // Equal-price match with the session closed
        session(1'b0, 1'b1);
        check("session_off", enable_count, 1'b0);
        send(0, 1'b0, 8'h20);
        send(1, 1'b1, 8'h20);
        check("t4_count_held", trade_count, 8'h02);

        // Start and stop together: stop wins
        session(1'b1, 1'b0);
        session(1'b1, 1'b1);
        check("start_stop_same", enable_count, 1'b0);

        // Counter wrap
        session(1'b1, 1'b0);
        n = 255 - int'(m_count);
        for (int i = 0; i < n; i++) begin
            send(0, 1'b0, 8'h80);
            send(1, 1'b1, 8'h7F);
        end
        check("count_255", trade_count, 8'hFF);
        send(0, 1'b0, 8'h80);
        send(1, 1'b1, 8'h7F);
        check("count_wrap", trade_count, 8'h00);

        // Reset while in LOAD: no ack, reset values everywhere
        req[0] = 1'b1; side[0] = 1'b0; price0 = 8'h33;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rl_ack", ack, 2'b00);
        check("rl_busy", busy, 1'b0);
        check("rl_buy", buy_price, 8'h00);
        check("rl_enable", enable_count, 1'b0);
        check("rl_count", trade_count, 8'h00);
        req = 2'b00;
        m_buy = 8'h00; m_sell = 8'hFF; m_en = 1'b0; m_count = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Pointer back at requester 0 after reset
        model_order(0, 1'b0, 8'h11);
        model_order(1, 1'b0, 8'h13);
        side = 2'b00; price0 = 8'h11; price1 = 8'h13;
        req  = 2'b11;
        acks = 0;
        for (int i = 0; i < 40 && acks < 2; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                if (ack[0]) req[0] = 1'b0;
                if (ack[1]) req[1] = 1'b0;
                acks++;
            end
        end
        req = 2'b00;
        check("post_rst_acks", acks, 2);
        wait_idle();
        send(1, 1'b1, 8'h13);

`ifdef MATCH_SCHEDULER_TRADE_PRICE_EN
        session(1'b1, 1'b0);
        send(0, 1'b0, 8'h41);
        send(1, 1'b1, 8'h3F);
        check("trade_price", trade_price, 8'h40);
`endif

        check("ack_q_empty", ack_q.size(), 0);
        check("match_q_empty", match_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
